xgmii_rx_engine: RTL and testbench

Receive-side counterpart of the XGMII transmit engine. It parses 10G XGMII frames from the link partner, accepts only UDP/IPv4 frames addressed to this interface that carry the team magic code, and buffers up to `MAX_WORDS` 64-bit payload words. Once the whole frame has passed every check, it flushes the payload into the 72-bit `{byte_valid, data}` FIFO used by the PCIe side.

---
 rtl/xgmii_rx_engine.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_xgmii_rx_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_engine.sv
// ---------------------------------------------------------------------------
// xgmii_rx_engine
//
// Receive-side XGMII parser. Accepts only UDP/IPv4 frames sent to this
// interface's MAC and IPv4 address on UDP port 9 that carry the magic code.
// Up to MAX_WORDS 64-bit payload words are buffered. A frame that passes
// every check is then flushed into the 72-bit {byte_valid, data} FIFO.
//
// Optional feature: define XGMII_RX_CRC_CHECK_EN to check the Ethernet FCS.
// The CRC-32 is computed over W1 through the last payload word and compared
// with lanes 0-3 of the terminate word. A mismatch drops the frame. The
// verdict is taken one edge after the terminate word is sampled.
// The magic code comes from the MAGIC_CODE macro (a default is given below).
//
// Ports
//   xgmii_clk       156.25 MHz clock; all logic uses the rising edge
//   sys_rst         asynchronous, active-high reset
//   xgmii_rxd       {rxc[7:0], rxd[63:0]}; lane 0 is the first byte on the wire
//   if_v4addr       local IPv4 address (quasi-static)
//   if_macaddr      local MAC address (quasi-static)
//   din             FIFO write word {8'hff, payload}
//   wr_en           FIFO write strobe (combinational)
//   full            FIFO full
//   rx_frame_count  number of accepted frames (wraps)
//   rx_drop_count   number of rejected frames (wraps)
//   dbg_state       FSM state: 0 IDLE, 1 HDR, 2 PAYLOAD, 3 DISCARD,
//                   4 FLUSH, 5 CRC_CHK
//
// FIFO handshake: a word moves to the FIFO on every cycle with wr_en high.
// wr_en is high only in FLUSH while full is low. While full is high, din
// holds the pending word.
// ---------------------------------------------------------------------------
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hc0de_5a1e
`endif

module xgmii_rx_engine #(
  parameter int MAX_WORDS = 8
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst,
  input  logic [71:0] xgmii_rxd,
  input  logic [31:0] if_v4addr,
  input  logic [47:0] if_macaddr,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  output logic [31:0] rx_frame_count,
  output logic [31:0] rx_drop_count,
  output logic [2:0]  dbg_state
);

  localparam int IW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int CW    = $clog2(MAX_WORDS + 1);
  localparam int DEPTH = 1 << IW;
  localparam logic [63:0] START_RXD = 64'hd5555555555555fb;
  localparam logic [31:0] MAGIC     = `MAGIC_CODE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DISCARD = 3'd3,
    S_FLUSH   = 3'd4,
    S_CRC_CHK = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;
  logic [31:0]     drop_cnt_q, drop_cnt_d;
  logic [63:0]     mem_q [DEPTH];
  logic            mem_we;

`ifdef XGMII_RX_CRC_CHECK_EN
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     fcs_q, fcs_d;

  // Reflected Ethernet CRC-32. Processes one 64-bit word, lane 0 first and
  // each byte LSB first.
  function automatic logic [31:0] crc32_d64(input logic [31:0] crc_in,
                                            input logic [63:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hedb88320;
      else                c = c >> 1;
    end
    return c;
  endfunction
`endif

  // ---- input decode -------------------------------------------------------
  logic [7:0]  rxc;
  logic [63:0] rxd;
  logic        is_start, is_term, is_data, has_fd, hdr_ok, buf_full, last_rd;

  assign rxc      = xgmii_rxd[71:64];
  assign rxd      = xgmii_rxd[63:0];
  assign is_start = (rxc == 8'h01) && (rxd == START_RXD);
  assign is_term  = (rxc == 8'hf0) && (rxd[39:32] == 8'hfd);
  assign is_data  = (rxc == 8'h00);
  assign buf_full = (wr_ptr_q == CW'(MAX_WORDS));
  assign last_rd  = ((CW'(rd_ptr_q) + CW'(1)) == wr_ptr_q);

  // A terminate control character in any lane ends a discarded frame.
  always_comb begin
    has_fd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rxc[i] && (rxd[8*i +: 8] == 8'hfd)) has_fd = 1'b1;
    end
  end

  // Header field checks. Multi-byte fields arrive MSB first, so they sit
  // byte-reversed in the little-endian lane order of rxd.
  always_comb begin
    hdr_ok = 1'b0;
    case (idx_q)
      3'd1: hdr_ok = (rxd[47:0] == {if_macaddr[7:0],   if_macaddr[15:8],
                                    if_macaddr[23:16], if_macaddr[31:24],
                                    if_macaddr[39:32], if_macaddr[47:40]});
      3'd2: hdr_ok = (rxd[63:32] == 32'h0045_0008);
      3'd3: hdr_ok = (rxd[63:56] == 8'h11);
      3'd4: hdr_ok = (rxd[63:48] == {if_v4addr[23:16], if_v4addr[31:24]});
      3'd5: hdr_ok = (rxd[15:0]  == {if_v4addr[7:0], if_v4addr[15:8]}) &&
                     (rxd[47:32] == 16'h0900);
      3'd6: hdr_ok = (rxd[47:16] == {MAGIC[7:0], MAGIC[15:8],
                                     MAGIC[23:16], MAGIC[31:24]});
      default: hdr_ok = 1'b0;
    endcase
  end

  // ---- next-state logic ---------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    mem_we      = 1'b0;
`ifdef XGMII_RX_CRC_CHECK_EN
    crc_d       = crc_q;
    fcs_d       = fcs_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          state_d  = S_HDR;
          idx_d    = 3'd1;
          wr_ptr_d = '0;
`ifdef XGMII_RX_CRC_CHECK_EN
          crc_d    = 32'hffffffff;
`endif
        end
      end

      S_HDR: begin
        if (is_start) begin
          // Restart on the new frame; the interrupted one counts as dropped.
          drop_cnt_d = drop_cnt_d + 32'd1;
          idx_d      = 3'd1;
          wr_ptr_d   = '0;
`ifdef XGMII_RX_CRC_CHECK_EN
          crc_d      = 32'hffffffff;
`endif
        end else if (!is_data || !hdr_ok) begin
          drop_cnt_d = drop_cnt_d + 32'd1;
          wr_ptr_d   = '0;
          state_d    = S_DISCARD;
        end else begin
`ifdef XGMII_RX_CRC_CHECK_EN
          crc_d = crc32_d64(crc_q, rxd);
`endif
          if (idx_q == 3'd6) state_d = S_PAYLOAD;
          else               idx_d   = idx_q + 3'd1;
        end
      end

      S_PAYLOAD: begin
        if (is_start) begin
          drop_cnt_d = drop_cnt_d + 32'd1;
          state_d    = S_HDR;
          idx_d      = 3'd1;
          wr_ptr_d   = '0;
`ifdef XGMII_RX_CRC_CHECK_EN
          crc_d      = 32'hffffffff;
`endif
        end else if (is_data) begin
          if (buf_full) begin
            drop_cnt_d = drop_cnt_d + 32'd1;
            wr_ptr_d   = '0;
            state_d    = S_DISCARD;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + CW'(1);
`ifdef XGMII_RX_CRC_CHECK_EN
            crc_d    = crc32_d64(crc_q, rxd);
`endif
          end
        end else if (is_term) begin
          if (wr_ptr_q == '0) begin
            drop_cnt_d = drop_cnt_d + 32'd1;
            state_d    = S_IDLE;
          end else begin
            rd_ptr_d = '0;
`ifdef XGMII_RX_CRC_CHECK_EN
            fcs_d    = rxd[31:0];
            state_d  = S_CRC_CHK;
`else
            frame_cnt_d = frame_cnt_d + 32'd1;
            state_d     = S_FLUSH;
`endif
          end
        end else begin
          // Any other control word. If it still carries a terminate, the
          // frame has ended; otherwise skip the rest of it.
          drop_cnt_d = drop_cnt_d + 32'd1;
          wr_ptr_d   = '0;
          state_d    = has_fd ? S_IDLE : S_DISCARD;
        end
      end

      S_DISCARD: begin
        if (is_start) begin
          state_d  = S_HDR;
          idx_d    = 3'd1;
          wr_ptr_d = '0;
`ifdef XGMII_RX_CRC_CHECK_EN
          crc_d    = 32'hffffffff;
`endif
        end else if (has_fd) begin
          state_d = S_IDLE;
        end
      end

`ifdef XGMII_RX_CRC_CHECK_EN
      S_CRC_CHK: begin
        if (is_start) drop_cnt_d = drop_cnt_d + 32'd1;
        // The FCS is the complemented CRC, sent low byte first in lane 0.
        if (~crc_q == fcs_q) begin
          frame_cnt_d = frame_cnt_d + 32'd1;
          state_d     = S_FLUSH;
        end else begin
          drop_cnt_d = drop_cnt_d + 32'd1;
          wr_ptr_d   = '0;
          state_d    = S_IDLE;
        end
      end
`endif

      S_FLUSH: begin
        // A start word here cannot be parsed, so that frame is lost.
        if (is_start) drop_cnt_d = drop_cnt_d + 32'd1;
        if (!full) begin
          if (last_rd) begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + IW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---- registers ----------------------------------------------------------
  always_ff @(posedge xgmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= 32'd0;
      drop_cnt_q  <= 32'd0;
`ifdef XGMII_RX_CRC_CHECK_EN
      crc_q       <= 32'hffffffff;
      fcs_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef XGMII_RX_CRC_CHECK_EN
      crc_q       <= crc_d;
      fcs_q       <= fcs_d;
`endif
    end
  end

  // The payload storage needs no reset; it is read only in FLUSH.
  always_ff @(posedge xgmii_clk) begin
    if (mem_we) mem_q[wr_ptr_q[IW-1:0]] <= rxd;
  end

  // ---- outputs ------------------------------------------------------------
  assign wr_en          = (state_q == S_FLUSH) && !full;
  assign din            = (state_q == S_FLUSH) ? {8'hff, mem_q[rd_ptr_q]} : 72'd0;
  assign rx_frame_count = frame_cnt_q;
  assign rx_drop_count  = drop_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_xgmii_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_xgmii_rx_engine
//
// Builds frames as byte lists: header fields, then payload. Individual header
// fields can be corrupted. The expected outcome is derived from frame-level
// rules: a frame is accepted if its header is intact and it has
// 1..MAX_WORDS payload words; otherwise it is dropped once.
// Writes expected from accepted frames are queued and compared as the DUT
// emits them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef MAGIC_CODE
`define MAGIC_CODE 32'hc0de_5a1e
`endif

module tb_xgmii_rx_engine;

  localparam int MAXW = 8;
  localparam logic [31:0] MAGIC   = `MAGIC_CODE;
  localparam logic [71:0] IDLE_W  = {8'hff, 64'h0707070707070707};
  localparam logic [71:0] START_W = {8'h01, 64'hd5555555555555fb};
  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'hc0a8_0105;

  // ---- clock / reset ------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic [71:0] rxd_in;
  logic [71:0] din;
  logic        wr_en;
  logic [31:0] fc, dc;
  logic [2:0]  dbg_state;

  always #3 clk = ~clk;

  xgmii_rx_engine #(.MAX_WORDS(MAXW)) dut (
    .xgmii_clk      (clk),
    .sys_rst        (rst),
    .xgmii_rxd      (rxd_in),
    .if_v4addr      (MY_IP),
    .if_macaddr     (MY_MAC),
    .din            (din),
    .wr_en          (wr_en),
    .full           (full),
    .rx_frame_count (fc),
    .rx_drop_count  (dc),
    .dbg_state      (dbg_state)
  );

  // ---- scoreboard ---------------------------------------------------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [71:0] exp_q[$];
  logic [31:0] mdl_frames = 32'd0;
  logic [31:0] mdl_drops  = 32'd0;
  logic        rand_full_en = 1'b0;

  logic [71:0] tx_q[$];
  logic [63:0] pay_q[$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every FIFO write must be the next expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (full) check("wr_gated", wr_en, 1'b0);
      if (wr_en) begin
        if (exp_q.size() == 0) check("unexp_wr", wr_en, 1'b0);
        else                   check("din", din, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_full_en) begin
      #1;
      full = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---- frame builder ------------------------------------------------------
  // kind: 0 good, 1 dest MAC, 2 ethertype/version, 3 protocol, 4 dst IP,
  //       5 dst port, 6 magic, 7 control char in header, 8 bad FCS
  task automatic make_frame(input int n, input int kind, input bit counting);
    logic [7:0]  b[$];
    logic [63:0] w;
    logic [31:0] fcs;
    logic [7:0]  mask;
    int          bad_word;
    b = {};
    for (int i = 0; i < 6; i++) b.push_back(MY_MAC[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    b.push_back(8'h08); b.push_back(8'h00); b.push_back(8'h45); b.push_back(8'h00);
    for (int i = 0; i < 7; i++) b.push_back(8'($urandom));
    b.push_back(8'h11);
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) b.push_back(MY_IP[31-8*i -: 8]);
    for (int i = 0; i < 2; i++) b.push_back(8'($urandom));
    b.push_back(8'h00); b.push_back(8'h09);
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) b.push_back(MAGIC[31-8*i -: 8]);
    for (int i = 0; i < 2; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 8*n; i++) b.push_back(counting ? 8'(i) : 8'($urandom));

    mask = 8'($urandom_range(1, 255));
    case (kind)
      1: b[$urandom_range(0, 5)]  ^= 8'(1 << $urandom_range(0, 7));
      2: b[12 + $urandom_range(0, 3)] ^= mask;
      3: b[23] ^= mask;
      4: b[30 + $urandom_range(0, 3)] ^= mask;
      5: b[36 + $urandom_range(0, 1)] ^= mask;
      6: b[42 + $urandom_range(0, 3)] ^= mask;
      default: ;
    endcase

`ifdef XGMII_RX_CRC_CHECK_EN
    fcs = 32'hffffffff;
    foreach (b[i]) begin
      fcs ^= {24'h0, b[i]};
      for (int k = 0; k < 8; k++) fcs = fcs[0] ? ((fcs >> 1) ^ 32'hedb88320) : (fcs >> 1);
    end
    fcs = ~fcs;
    if (kind == 8) fcs[7:0] = ~fcs[7:0];
`else
    fcs = $urandom;
`endif

    bad_word = $urandom_range(0, 5);
    tx_q  = {};
    pay_q = {};
    tx_q.push_back(START_W);
    for (int k = 0; k < 6 + n; k++) begin
      for (int j = 0; j < 8; j++) w[8*j +: 8] = b[8*k + j];
      if (kind == 7 && k == bad_word) begin
        w[31:24] = 8'hfe;
        tx_q.push_back({8'h08, w});
      end else begin
        tx_q.push_back({8'h00, w});
      end
      if (k >= 6) pay_q.push_back(w);
    end
    tx_q.push_back({8'hf0, 8'h07, 8'h07, 8'h07, 8'hfd, fcs});
  endtask

  task automatic model_frame(input int n, input int kind);
    if (kind == 0 && n >= 1 && n <= MAXW) begin
      foreach (pay_q[i]) exp_q.push_back({8'hff, pay_q[i]});
      mdl_frames++;
    end else begin
      mdl_drops++;
    end
  endtask

  // ---- driver tasks -------------------------------------------------------
  task automatic drive(input logic [71:0] w);
    @(posedge clk);
    #1;
    rxd_in = w;
  endtask

  task automatic send_frame();
    foreach (tx_q[i]) drive(tx_q[i]);
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) drive(IDLE_W);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) drive(IDLE_W);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frames"}, fc, mdl_frames);
    check({tag, "_drops"},  dc, mdl_drops);
  endtask

  // ---- stimulus -----------------------------------------------------------
  initial begin
    int n, kind;
    rst    = 1'b1;
    full   = 1'b0;
    rxd_in = IDLE_W;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en",  wr_en, 1'b0);
    check("rst_din",    din, 72'd0);
    check("rst_frames", fc, 32'd0);
    check("rst_drops",  dc, 32'd0);
    check("rst_state",  dbg_state, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Good frame with counting payload.
    make_frame(2, 0, 1'b1);
    model_frame(2, 0);
    check("good_pay0", exp_q[0], {8'hff, 64'h0706050403020100});
    send_frame();
    drain();
    check_counts("good");

    // One-bit MAC error, then wrong magic.
    make_frame(2, 1, 1'b1); model_frame(2, 1); send_frame(); drain();
    make_frame(2, 6, 1'b1); model_frame(2, 6); send_frame(); drain();
    check_counts("hdr_bad");

    // Payload overflow: back in IDLE right after the terminate.
    make_frame(MAXW + 1, 0, 1'b0);
    model_frame(MAXW + 1, 0);
    send_frame();
    drive(IDLE_W);
    @(negedge clk);
    check("ovf_idle", dbg_state, 3'd0);
    drain();
    check_counts("ovf");

    // Backpressure on the first three flush cycles of a 4-word frame.
    make_frame(4, 0, 1'b0);
    model_frame(4, 0);
    send_frame();
`ifdef XGMII_RX_CRC_CHECK_EN
    drive(IDLE_W);
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 rxd_in = IDLE_W; full = 1'b1;
      @(negedge clk);
      check("bp_hold", wr_en, 1'b0);
      check("bp_din_hold", din, {8'hff, pay_q[0]});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 rxd_in = IDLE_W; full = 1'b0;
      @(negedge clk);
      check("bp_burst", wr_en, 1'b1);
    end
    drain();
    check_counts("bp");

    // Second frame starts during flush: first frame written, second lost.
    make_frame(4, 0, 1'b0);
    model_frame(4, 0);
    send_frame();
    drive(IDLE_W);
    make_frame(3, 0, 1'b0);
    mdl_drops++;
    send_frame();
    drain();
    check_counts("flush_start");

    // Start word in the middle of the header restarts parsing.
    make_frame(2, 0, 1'b0);
    for (int i = 0; i < 4; i++) drive(tx_q[i]);
    mdl_drops++;
    make_frame(3, 0, 1'b0);
    model_frame(3, 0);
    send_frame();
    drain();
    check_counts("restart");

`ifdef XGMII_RX_CRC_CHECK_EN
    make_frame(2, 0, 1'b1); model_frame(2, 0); send_frame(); drain();
    check_counts("crc_good");
    make_frame(2, 8, 1'b1); model_frame(2, 8); send_frame(); drain();
    check_counts("crc_bad");
`endif

    // Reset in the middle of a flush: nothing more is written.
    make_frame(4, 0, 1'b0);
    send_frame();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 rxd_in = IDLE_W; full = 1'b1;
    end
    @(posedge clk);
    #1 full = 1'b0; rst = 1'b1;
    exp_q.delete();
    mdl_frames = 32'd0;
    mdl_drops  = 32'd0;
    @(negedge clk);
    check("mid_rst_wr_en", wr_en, 1'b0);
    check("mid_rst_din",   din, 72'd0);
    check("mid_rst_state", dbg_state, 3'd0);
    check_counts("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) drive(IDLE_W);
    check_counts("post_rst");

    // Randomized frames under random backpressure.
    rand_full_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      kind = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
      case ($urandom_range(0, 5))
        0:       n = 0;
        1:       n = MAXW;
        2:       n = MAXW + 1;
        default: n = $urandom_range(1, MAXW);
      endcase
      make_frame(n, kind, 1'b0);
      model_frame(n, kind);
      send_frame();
      drain();
      check_counts("rand");
    end
    rand_full_en = 1'b0;
    drive(IDLE_W);
    full = 1'b0;
    repeat (4) drive(IDLE_W);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
